// File: rtl/cirno9_uart.sv
// Memory-mapped UART responder: 4-entry TX FIFO feeding an 8N1 transmitter, programmable baud divisor,
// and an optional 8N1 receiver built only when CIRNO9_UART_RX_EN is defined.
//
// TX state | meaning
// IDLE     | line high, waiting for the FIFO to become non-empty
// START    | start bit (0) for DIV cycles
// DATA     | 8 data bits LSB first, DIV cycles each
// STOP     | stop bit (1) for DIV cycles; chains straight into START if more data is queued
//
// RX state | meaning
// IDLE     | waiting for a falling edge on the synchronized line
// START    | waiting DIV/2 to re-check the start bit
// DATA     | sampling 8 data bits every DIV cycles
// STOP     | sampling the stop bit, then delivering the byte or flagging a framing error
module cirno9_uart #(
    parameter logic [15:0] DIV_RST = 16'd434,
    parameter int          TXF_AW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iob_val,
    output logic        iob_rdy,
    input  logic [31:0] iob_adr,
    input  logic [3:0]  iob_wen,
    input  logic [31:0] iob_wdat,
    output logic [31:0] iob_rdat,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int TXF_D = 1 << TXF_AW;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t   tx_st_q, tx_st_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_q, tx_d;
    logic        rdy_q;
    logic [31:0] rdat_q, rdat_d;
    logic [15:0] div_q, div_d, div_eff;
    logic [7:0]  fifo_q [TXF_D];
    logic [TXF_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        empty, full, push, pop, tx_last, tx_idle;
    logic [1:0]  sel;
    logic        is_rd, is_wr;
    logic        rx_valid, rx_ovr, rx_ferr;
    logic [7:0]  rx_byte;
    logic        unused_ok;

    assign unused_ok = ^{iob_adr[31:4], iob_adr[1:0], iob_wen[3:2], iob_wdat[31:16]};

    assign sel     = iob_adr[3:2];
    assign is_rd   = iob_val && (iob_wen == 4'h0);
    assign is_wr   = iob_val && (iob_wen != 4'h0);
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[TXF_AW] != rd_ptr_q[TXF_AW]) &&
                     (wr_ptr_q[TXF_AW-1:0] == rd_ptr_q[TXF_AW-1:0]);
    assign push    = is_wr && (sel == 2'd0) && iob_wen[0] && (!full || pop);
    assign tx_idle = empty && (tx_st_q == TX_IDLE);
    assign tx_last = (tx_cnt_q == 16'd0);

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_last ? tx_cnt_q : tx_cnt_q - 16'd1;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        pop      = 1'b0;
        case (tx_st_q)
            TX_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    tx_sh_d  = fifo_q[rd_ptr_q[TXF_AW-1:0]];
                    tx_cnt_d = div_eff - 16'd1;
                    tx_st_d  = TX_START;
                end
            end
            TX_START: begin
                if (tx_last) begin
                    tx_cnt_d = div_eff - 16'd1;
                    tx_bit_d = 3'd0;
                    tx_st_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_last) begin
                    tx_cnt_d = div_eff - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (tx_last) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        tx_sh_d  = fifo_q[rd_ptr_q[TXF_AW-1:0]];
                        tx_cnt_d = div_eff - 16'd1;
                        tx_st_d  = TX_START;
                    end else begin
                        tx_st_d = TX_IDLE;
                    end
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase
        // Line level is registered from the next state so it changes exactly at bit boundaries.
        case (tx_st_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_sh_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        div_d    = div_q;
        if (is_wr && (sel == 2'd2)) begin
            if (iob_wen[0]) div_d[7:0]  = iob_wdat[7:0];
            if (iob_wen[1]) div_d[15:8] = iob_wdat[15:8];
        end
        rdat_d = 32'h0;
        if (is_rd) begin
            case (sel)
                2'd0:    rdat_d = {rx_valid, 23'h0, rx_byte};
                2'd1:    rdat_d = {27'h0, rx_ferr, rx_ovr, rx_valid, tx_idle, full};
                2'd2:    rdat_d = {16'h0, div_q};
                default: rdat_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[TXF_AW-1:0]] <= iob_wdat[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= 16'd0;
            tx_bit_q <= 3'd0;
            tx_sh_q  <= 8'h00;
            tx_q     <= 1'b1;
            rdy_q    <= 1'b0;
            rdat_q   <= 32'h0;
            div_q    <= DIV_RST;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            tx_q     <= tx_d;
            rdy_q    <= iob_val;
            rdat_q   <= rdat_d;
            div_q    <= div_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign iob_rdy  = rdy_q;
    assign iob_rdat = rdat_q;
    assign uart_tx  = tx_q;

`ifdef CIRNO9_UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
    logic        rx_last, rx_done, ferr_set, ovr_set, rd_data, clr_ovr, clr_ferr;

    assign rx_last  = (rx_cnt_q == 16'd0);
    assign rd_data  = is_rd && (sel == 2'd0);
    assign clr_ovr  = is_wr && (sel == 2'd1) && iob_wen[0] && iob_wdat[3];
    assign clr_ferr = is_wr && (sel == 2'd1) && iob_wen[0] && iob_wdat[4];

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_last ? rx_cnt_q : rx_cnt_q - 16'd1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_done  = 1'b0;
        ferr_set = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d = div_eff >> 1;
                    rx_st_d  = RX_START;
                end
            end
            RX_START: begin
                if (rx_last) begin
                    if (rx_s2_q) begin
                        rx_st_d = RX_IDLE;
                    end else begin
                        rx_cnt_d = div_eff - 16'd1;
                        rx_bit_d = 3'd0;
                        rx_st_d  = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_last) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = div_eff - 16'd1;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_last) begin
                    rx_st_d  = RX_IDLE;
                    rx_done  = rx_s2_q;
                    ferr_set = !rx_s2_q;
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
        // A read racing a completing byte hands the slot straight to the new byte.
        rx_valid_d = rx_valid_q;
        rx_byte_d  = rx_byte_q;
        ovr_set    = 1'b0;
        if (rx_done && (!rx_valid_q || rd_data)) begin
            rx_byte_d  = rx_sh_q;
            rx_valid_d = 1'b1;
        end else begin
            ovr_set = rx_done;
            if (rd_data) rx_valid_d = 1'b0;
        end
        rx_ovr_d  = (rx_ovr_q && !clr_ovr) || ovr_set;
        rx_ferr_d = (rx_ferr_q && !clr_ferr) || ferr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_ovr   = rx_ovr_q;
    assign rx_ferr  = rx_ferr_q;
    assign rx_byte  = rx_byte_q;
`else
    logic unused_rx;

    assign unused_rx = uart_rx;
    assign rx_valid  = 1'b0;
    assign rx_ovr    = 1'b0;
    assign rx_ferr   = 1'b0;
    assign rx_byte   = 8'h00;
`endif

endmodule
